// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default width and iteration-counter sizing for seq_divider
package div_pkg;
  localparam int DW_DEF = 32;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  function automatic int cnt_width(input int dw);
    return dw > 1 ? $clog2(dw) : 1;
  endfunction
  localparam int CNT_W = cnt_width(DW_DEF);
endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: conditional two's-complement negate (abs on entry, sign restore on exit)
module div_sign_fix import div_pkg::*; #(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] a,
  input  logic          neg,
  output logic [DW-1:0] y
);
  assign y = neg ? -a : a;
endmodule

// File: rtl/seq_divider.sv
// seq_divider: restoring sequential divider, signed/unsigned; SEQ_DIV_ZERO_FLAG_EN adds DivZero output
module seq_divider import div_pkg::*; #(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Start,
  input  logic          Signed,
  input  logic [DW-1:0] Dividend,
  input  logic [DW-1:0] Divisor,
  output logic          Busy,
  output logic          Done,
  output logic [DW-1:0] Quotient,
  output logic [DW-1:0] Remainder
`ifdef SEQ_DIV_ZERO_FLAG_EN
  ,
  output logic          DivZero
`endif
);
  localparam int CW = cnt_width(DW);
  state_t state, nxt;
  logic pend, sq, sr, idle, acc, dz;
  logic [CW-1:0] cnt;
  logic [DW-1:0] q, r, d, a_out, b_out;
  logic [DW:0] rs, sub;
  assign idle = state == IDLE;
  assign Busy = !idle || pend;
  assign acc = Start && !Busy;
  assign dz = Divisor == '0;
  assign rs = {r, q[DW-1]};
  assign sub = rs - {1'b0, d};
  // Shared negators: operand magnitudes while idle, sign restore of quotient/remainder in FIX
  div_sign_fix #(.DW(DW)) u_q (
    .a(idle ? Dividend : q),
    .neg(idle ? Signed && Dividend[DW-1] : sq),
    .y(a_out)
  );
  div_sign_fix #(.DW(DW)) u_r (
    .a(idle ? Divisor : r),
    .neg(idle ? Signed && Divisor[DW-1] : sr),
    .y(b_out)
  );
  // State register
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  // Next state: zero divisor bypasses CALC/FIX through the pend flag
  always_comb begin
    nxt = state;
    if (idle && acc && !dz) nxt = CALC;
    else if (state == CALC && cnt == CW'(DW-1)) nxt = FIX;
    else if (state == FIX) nxt = IDLE;
  end
  // Datapath: operand capture, one shift-subtract step per CALC cycle, result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      Done <= 1'b0;
      Quotient <= '0;
      Remainder <= '0;
      q <= '0;
      r <= '0;
      d <= '0;
      cnt <= '0;
      sq <= 1'b0;
      sr <= 1'b0;
    end else begin
      Done <= pend || state == FIX;
      pend <= acc && dz;
      if (acc) begin
        q <= dz ? Dividend : a_out;
        r <= '0;
        d <= b_out;
        cnt <= '0;
        sq <= Signed && (Dividend[DW-1] ^ Divisor[DW-1]);
        sr <= Signed && Dividend[DW-1];
      end else if (state == CALC) begin
        q <= {q[DW-2:0], ~sub[DW]};
        r <= sub[DW] ? rs[DW-1:0] : sub[DW-1:0];
        cnt <= cnt + 1'b1;
      end
      if (pend) begin
        Quotient <= '1;
        Remainder <= q;
      end else if (state == FIX) begin
        Quotient <= a_out;
        Remainder <= b_out;
      end
    end
  end
`ifdef SEQ_DIV_ZERO_FLAG_EN
  // Divide-by-zero flag: raised with Done, dropped on the next accepted Start
  always_ff @(posedge clk) begin
    if (rst) DivZero <= 1'b0;
    else if (acc) DivZero <= 1'b0;
    else if (pend) DivZero <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider (optionally with SEQ_DIV_ZERO_FLAG_EN)
module tb_seq_divider;
  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int lat;
  } exp_t;
  logic clk = 0, rst = 1, Start = 0, Signed = 0;
  logic [31:0] Dividend = 0, Divisor = 0;
  logic Busy, Done;
  logic [31:0] Quotient, Remainder;
`ifdef SEQ_DIV_ZERO_FLAG_EN
  logic dz_flag;
`endif
  int checks = 0, errors = 0;
  exp_t sb[$];
  exp_t last;

  seq_divider dut (
    .clk(clk),
    .rst(rst),
    .Start(Start),
    .Signed(Signed),
    .Dividend(Dividend),
    .Divisor(Divisor),
    .Busy(Busy),
    .Done(Done),
    .Quotient(Quotient),
    .Remainder(Remainder)
`ifdef SEQ_DIV_ZERO_FLAG_EN
    ,
    .DivZero(dz_flag)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    logic signed [31:0] sa, sbv;
    sa = a;
    sbv = b;
    e.lat = (b == 0) ? 2 : 34;
    if (b == 0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 0;
    end else if (s) begin
      e.q = sa / sbv;
      e.r = sa % sbv;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int inj, input string name);
    exp_t e;
    int n;
    bit busy_bad;
    sb.push_back(model(a, b, s));
    Start = 1;
    Signed = s;
    Dividend = a;
    Divisor = b;
    tick();
    Start = 0;
    Signed = $urandom_range(0, 1);
    Dividend = $urandom;
    Divisor = $urandom;
    n = 1;
    busy_bad = 0;
    while (!Done && n < 60) begin
      if (Busy !== 1'b1) busy_bad = 1;
      if (n == inj) begin
        Start = 1;
        Signed = 0;
        Dividend = 50;
        Divisor = 5;
      end
      tick();
      Start = 0;
      n++;
    end
    e = sb.pop_front();
    last = e;
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL %s busy_during_op: Busy dropped before Done, required high", name);
    end
    checks++;
    if (!Done) begin
      errors++;
      $display("FAIL %s timeout: no Done within %0d cycles, required at cycle %0d", name, n, e.lat);
    end
    checks++;
    if (n !== e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", name, n, e.lat);
    end
    checks++;
    if (Quotient !== e.q) begin
      errors++;
      $display("FAIL %s quotient: got %h required %h", name, Quotient, e.q);
    end
    checks++;
    if (Remainder !== e.r) begin
      errors++;
      $display("FAIL %s remainder: got %h required %h", name, Remainder, e.r);
    end
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b required 0", name, Busy);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    Start = 1;
    Dividend = 100;
    Divisor = 7;
    tick();
    tick();
    Start = 0;
    rst = 0;
    checks++;
    if ({Busy, Done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctrl: Busy/Done got %b required 00", {Busy, Done});
    end
    checks++;
    if ({Quotient, Remainder} !== 64'd0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h required 0/0", Quotient, Remainder);
    end
`ifdef SEQ_DIV_ZERO_FLAG_EN
    checks++;
    if (dz_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_divzero: got %b required 0", dz_flag);
    end
`endif
  endtask

  task automatic test_unsigned();
    run_op(100, 7, 0, 0, "u_100_7");
    for (int i = 0; i < 4; i++) run_op($urandom, $urandom_range(1, 32'hFFFF_FFFF), 0, 0, "u_rand");
    run_op(32'hFFFF_FFFF, 1, 0, 0, "u_max_1");
    run_op(3, 32'hFFFF_FFFF, 0, 0, "u_small_big");
    run_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0, "u_msb_div");
`ifdef SEQ_DIV_ZERO_FLAG_EN
    checks++;
    if (dz_flag !== 1'b0) begin
      errors++;
      $display("FAIL divzero_clear: got %b required 0", dz_flag);
    end
`endif
  endtask

  task automatic test_signed();
    run_op(32'hFFFF_FFF9, 2, 1, 0, "s_m7_2");
    run_op(7, 32'hFFFF_FFFE, 1, 0, "s_7_m2");
    run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1, 0, "s_m100_m7");
    for (int i = 0; i < 4; i++) run_op($urandom, $urandom_range(1, 32'hFFFF_FFFF), 1, 0, "s_rand");
  endtask

  task automatic test_overflow();
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1, 0, "s_overflow");
  endtask

  task automatic test_zero_div();
    run_op(5, 0, 0, 0, "z_u_5_0");
`ifdef SEQ_DIV_ZERO_FLAG_EN
    checks++;
    if (dz_flag !== 1'b1) begin
      errors++;
      $display("FAIL divzero_set: got %b required 1", dz_flag);
    end
`endif
    run_op(32'hFFFF_FFF0, 0, 1, 0, "z_s_m16_0");
  endtask

  task automatic test_hold();
    logic [31:0] q0, r0;
    q0 = last.q;
    r0 = last.r;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (Quotient !== q0 || Remainder !== r0) begin
      errors++;
      $display("FAIL hold: got %h/%h required %h/%h", Quotient, Remainder, q0, r0);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    Start = 1;
    Signed = 0;
    Dividend = 100;
    Divisor = 7;
    tick();
    Start = 0;
    for (int n = 1; n < 10; n++) tick();
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if ({Busy, Done} !== 2'b00 || {Quotient, Remainder} !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b %h/%h required all 0", Busy, Done, Quotient, Remainder);
    end
    seen = 0;
    for (int n = 11; n <= 40; n++) begin
      if (Done) seen = 1;
      tick();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_no_done: got Done after reset, required none");
    end
    rst = 1;
    Start = 1;
    tick();
    rst = 0;
    Start = 0;
    tick();
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: Busy got %b required 0", Busy);
    end
    run_op(100, 7, 0, 0, "post_reset");
  endtask

  task automatic test_busy_start();
    bit seen;
    run_op(100, 7, 0, 5, "busy_start");
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (Done || Busy) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL busy_start_ignored: second op ran, required ignored");
    end
  endtask

  task automatic test_back_to_back();
    run_op(1000, 10, 0, 0, "b2b_1");
    run_op(77, 0, 1, 0, "b2b_2");
    run_op(32'hFFFF_FF00, 16, 1, 0, "b2b_3");
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_hold();
    test_signed();
    test_overflow();
    test_zero_div();
    test_reset_mid();
    test_busy_start();
    test_back_to_back();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
